// File: rtl/fb_rect_writer.sv
// rtl/fb_rect_writer.sv - filled-rectangle write engine for the 320x240 12-bit frame buffer
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 17
`endif

module fb_rect_writer #(
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 240,
  parameter int ADDR_WIDTH = `DISP_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [8:0]            cmd_x0,
  input  logic [7:0]            cmd_y0,
  input  logic [8:0]            cmd_w,
  input  logic [7:0]            cmd_h,
  input  logic [11:0]           cmd_color,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_write_addr,
  output logic [11:0]           fb_write_data,
  input  logic                  fb_wr_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_FILL, S_DONE} state_t;

  localparam logic [9:0] W10 = 10'(FB_WIDTH);
  localparam logic [9:0] H10 = 10'(FB_HEIGHT);

  state_t                state_q, state_d;
  logic [8:0]            x0_q, x0_d, w_q, w_d, x_q, x_d, x_last_q, x_last_d;
  logic [7:0]            y0_q, y0_d, h_q, h_d, y_q, y_d, y_last_q, y_last_d;
  logic [11:0]           color_q, color_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [9:0]            x_end, y_end;

  // registered outputs, next values come from the output process
  logic                  fb_we_q, fb_we_d, busy_q, busy_d, done_q, done_d, cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [11:0]           data_q, data_d;

  // state, datapath and output registers; reset aborts any command in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      x_last_q    <= '0;
      y_last_q    <= '0;
      row_base_q  <= '0;
      fb_we_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x_last_q    <= x_last_d;
      y_last_q    <= y_last_d;
      row_base_q  <= row_base_d;
      fb_we_q     <= fb_we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // next state: latch command, clip against the frame, raster walk with stall hold
  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    x_d        = x_q;
    y_d        = y_q;
    x_last_d   = x_last_q;
    y_last_d   = y_last_q;
    row_base_d = row_base_q;
    // 10-bit sums so x0+w / y0+h never wrap before the clamp
    x_end      = {1'b0, x0_q} + {1'b0, w_q};
    y_end      = {2'b0, y0_q} + {2'b0, h_q};
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          x0_d    = cmd_x0;
          y0_d    = cmd_y0;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          state_d = S_CLIP;
        end
      end
      S_CLIP: begin
        x_last_d = (x_end > W10) ? 9'(W10 - 10'd1) : 9'(x_end - 10'd1);
        y_last_d = (y_end > H10) ? 8'(H10 - 10'd1) : 8'(y_end - 10'd1);
        if (w_q == '0 || h_q == '0 || {1'b0, x0_q} >= W10 || {2'b0, y0_q} >= H10) begin
          state_d = S_DONE;
        end else begin
          x_d        = x0_q;
          y_d        = y0_q;
          row_base_d = ADDR_WIDTH'(y0_q) * ADDR_WIDTH'(FB_WIDTH);
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (fb_wr_ready) begin
          if (x_q < x_last_q) begin
            x_d = x_q + 9'd1;
          end else if (y_q < y_last_q) begin
            x_d        = x0_q;
            y_d        = y_q + 8'd1;
            row_base_d = row_base_q + ADDR_WIDTH'(FB_WIDTH);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // output values registered alongside the state they belong to
  always_comb begin
    fb_we_d     = (state_d == S_FILL);
    addr_d      = fb_we_d ? (row_base_d + ADDR_WIDTH'(x_d)) : addr_q;
    data_d      = fb_we_d ? color_d : data_q;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  assign fb_we         = fb_we_q;
  assign fb_write_addr = addr_q;
  assign fb_write_data = data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cmd_ready     = cmd_ready_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// tb/tb_fb_rect_writer.sv - directed self-checking bench for fb_rect_writer
module tb_fb_rect_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x0;
  logic [7:0]  cmd_y0;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [11:0] cmd_color;
  logic        fb_we;
  logic [16:0] fb_write_addr;
  logic [11:0] fb_write_data;
  logic        fb_wr_ready;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  int          neg_cnt = 0;
  int          acc_neg = 0;
  logic [16:0] wa[$];
  logic [11:0] wd[$];
  int          wc[$];
  int          done_c[$];
  bit          bad_addr = 1'b0;

  fb_rect_writer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .fb_we(fb_we), .fb_write_addr(fb_write_addr), .fb_write_data(fb_write_data),
    .fb_wr_ready(fb_wr_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // record completed writes and done pulses mid-cycle
  always @(negedge clk) begin
    neg_cnt++;
    if (fb_we && fb_wr_ready) begin
      wa.push_back(fb_write_addr);
      wd.push_back(fb_write_data);
      wc.push_back(neg_cnt);
    end
    if (fb_we && fb_write_addr >= 17'd76800) bad_addr = 1'b1;
    if (done) done_c.push_back(neg_cnt);
  end

  // returns inside cycle 1 (the cycle after the accept edge)
  task automatic start_cmd(input int x0, input int y0, input int w, input int h, input int color);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL start_wait: cmd_ready=%b required 1", cmd_ready); end
    wa.delete(); wd.delete(); wc.delete(); done_c.delete();
    cmd_x0 = 9'(x0); cmd_y0 = 8'(y0); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = 12'(color);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc_neg = neg_cnt;
  endtask

  // returns in the cycle after the done pulse
  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b0; fb_wr_ready = 1'b1;
    cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (2) @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b0 || fb_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_ctl: ready/we/busy/done=%b%b%b%b required 0000", cmd_ready, fb_we, busy, done);
    end
    total++;
    if (fb_write_addr !== 17'd0 || fb_write_data !== 12'd0) begin
      bad++; $display("FAIL reset_bus: addr=%0d data=%h required 0/000", fb_write_addr, fb_write_data);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_release: ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_rect;
    int exp_a[4] = '{1610, 1611, 1930, 1931};
    int exp_c[4] = '{2, 3, 4, 5};
    bit got;
    start_cmd(10, 5, 2, 2, 12'hF00);
    total++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL rect_clip_cycle: ready=%b busy=%b required 0/1", cmd_ready, busy);
    end
    wait_done(100, got);
    total++;
    if (!got || wa.size() != 4) begin
      bad++; $display("FAIL rect_count: done=%b writes=%0d required 1/4", got, wa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wa[i] !== 17'(exp_a[i]) || wd[i] !== 12'hF00 || wc[i] - acc_neg != exp_c[i]) begin
          bad++; $display("FAIL rect_write%0d: addr=%0d data=%h cyc=%0d required %0d/F00/%0d",
                          i, wa[i], wd[i], wc[i] - acc_neg, exp_a[i], exp_c[i]);
        end
      end
    end
    total++;
    if (done_c.size() != 1 || done_c[0] - acc_neg != 6) begin
      bad++; $display("FAIL rect_done: pulses=%0d required 1 at cycle 6", done_c.size());
    end
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rect_idle: ready=%b busy=%b done=%b required 1/0/0", cmd_ready, busy, done);
    end
  endtask

  task automatic test_clip;
    bit got;
    bad_addr = 1'b0;
    start_cmd(318, 239, 4, 3, 12'h0A5);
    wait_done(100, got);
    total++;
    if (!got || wa.size() != 2) begin
      bad++; $display("FAIL clip_count: done=%b writes=%0d required 1/2", got, wa.size());
    end else begin
      total++;
      if (wa[0] !== 17'd76798 || wa[1] !== 17'd76799 || wd[1] !== 12'h0A5) begin
        bad++; $display("FAIL clip_addr: addr=%0d,%0d data=%h required 76798,76799/0A5", wa[0], wa[1], wd[1]);
      end
    end
    total++;
    if (done_c.size() != 1 || done_c[0] - acc_neg != 4) begin
      bad++; $display("FAIL clip_done: pulses=%0d required 1 at cycle 4", done_c.size());
    end
  endtask

  task automatic test_empty;
    int xs[2] = '{5, 320};
    int ws[2] = '{0, 4};
    bit got;
    for (int k = 0; k < 2; k++) begin
      start_cmd(xs[k], 3, ws[k], 2, 12'hFFF);
      @(posedge clk); #1;
      total++;
      if (done !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL empty%0d_c2: done=%b ready=%b busy=%b required 1/0/1", k, done, cmd_ready, busy);
      end
      @(posedge clk); #1;
      total++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || wa.size() != 0) begin
        bad++; $display("FAIL empty%0d_c3: ready=%b busy=%b writes=%0d required 1/0/0", k, cmd_ready, busy, wa.size());
      end
    end
    got = 1'b0;
  endtask

  task automatic test_stall;
    int exp_a[4] = '{1610, 1611, 1930, 1931};
    int exp_c[4] = '{2, 6, 7, 8};
    bit got;
    start_cmd(10, 5, 2, 2, 12'hF00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    fb_wr_ready = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      if (c == 6) fb_wr_ready = 1'b1;
      total++;
      if (fb_we !== 1'b1 || fb_write_addr !== 17'd1611 || fb_write_data !== 12'hF00) begin
        bad++; $display("FAIL stall_hold_c%0d: we=%b addr=%0d data=%h required 1/1611/F00", c, fb_we, fb_write_addr, fb_write_data);
      end
      if (c < 6) begin @(posedge clk); #1; end
    end
    wait_done(100, got);
    total++;
    if (!got || wa.size() != 4) begin
      bad++; $display("FAIL stall_count: done=%b writes=%0d required 1/4", got, wa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wa[i] !== 17'(exp_a[i]) || wc[i] - acc_neg != exp_c[i]) begin
          bad++; $display("FAIL stall_write%0d: addr=%0d cyc=%0d required %0d/%0d", i, wa[i], wc[i] - acc_neg, exp_a[i], exp_c[i]);
        end
      end
    end
    total++;
    if (done_c.size() != 1 || done_c[0] - acc_neg != 9) begin
      bad++; $display("FAIL stall_done: pulses=%0d required 1 at cycle 9", done_c.size());
    end
  endtask

  task automatic test_clear;
    bit got;
    int mis = 0;
    start_cmd(0, 0, 320, 240, 12'h000);
    wait_done(80000, got);
    total++;
    if (!got || wa.size() != 76800) begin
      bad++; $display("FAIL clear_count: done=%b writes=%0d required 1/76800", got, wa.size());
    end else begin
      for (int i = 0; i < 76800; i++) if (wa[i] !== 17'(i) || wd[i] !== 12'h000) mis++;
      total++;
      if (mis != 0) begin
        bad++; $display("FAIL clear_order: bad_entries=%0d required 0", mis);
      end
    end
    total++;
    if (done_c.size() != 1 || done_c[0] - acc_neg != 76802) begin
      bad++; $display("FAIL clear_done: pulses=%0d required 1 at cycle 76802", done_c.size());
    end
    total++;
    if (bad_addr) begin
      bad++; $display("FAIL addr_range: address>=76800 driven=%b required 0", bad_addr);
    end
  endtask

  task automatic test_reset_mid;
    int n0;
    start_cmd(0, 0, 320, 240, 12'h123);
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (fb_we !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL midreset_pre: we=%b busy=%b required 1/1", fb_we, busy);
    end
    reset = 1'b1;
    #1;
    n0 = wa.size();
    total++;
    if (fb_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL midreset_async: we/busy/done/ready=%b%b%b%b required 0000", fb_we, busy, done, cmd_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL midreset_release: ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (wa.size() != n0 || fb_we !== 1'b0 || done_c.size() != 0) begin
      bad++; $display("FAIL midreset_quiet: new_writes=%0d we=%b dones=%0d required 0/0/0", wa.size() - n0, fb_we, done_c.size());
    end
  endtask

  initial begin
    test_reset();
    test_rect();
    test_clip();
    test_empty();
    test_stall();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
